// File: rtl/avalon_rx_axis_pkt_fifo.sv
// avalon_rx_axis_pkt_fifo: store-and-forward packet FIFO from the aligned RX beat stream to an AXI4-Stream master
module avalon_rx_axis_pkt_fifo #(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int BE_WIDTH       = AXI_DATA_WIDTH / 8,
    parameter int FIFO_DEPTH     = 32,
    parameter int READY_MARGIN   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_DATA_WIDTH-1:0] trn_rd,
    input  logic [BE_WIDTH-1:0]       trn_rrem,
    input  logic                      trn_rsof,
    input  logic                      trn_reof,
    input  logic                      trn_rsrc_rdy,
    input  logic [7:0]                trn_rbar_hit,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_rx_tdata,
    output logic [BE_WIDTH-1:0]       m_axis_rx_tkeep,
    output logic                      m_axis_rx_tlast,
    output logic [8:0]                m_axis_rx_tuser,
    output logic                      m_axis_rx_tvalid,
    input  logic                      m_axis_rx_tready,
    output logic                      rx_st_ready_o,
    output logic                      err_overflow,
    output logic                      err_frame,
    output logic [15:0]               drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int MW = AXI_DATA_WIDTH + BE_WIDTH + 10;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PKT  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [PW-1:0] wr_ptr, cmt_ptr, cmt_pub, rd_ptr, used, free, base;
    logic [7:0]    bar_q, beat_bar;
    logic [MW-1:0] mem [FIFO_DEPTH];
    logic [MW-1:0] rd_word;
    logic          start, cont, frame_bad, full, ovf, wen, rd_en;

    assign used      = wr_ptr - rd_ptr;
    assign free      = PW'(FIFO_DEPTH) - used;
    assign full      = used == PW'(FIFO_DEPTH);
    assign start     = trn_rsrc_rdy & trn_rsof;
    assign cont      = trn_rsrc_rdy & ~trn_rsof & (state == PKT);
    assign frame_bad = trn_rsrc_rdy & (trn_rsof ? state != IDLE : state == IDLE);
    assign ovf       = (start | cont) & full;
    assign wen       = (start | cont) & ~full;
    // A SOF always begins at the committed pointer, which also rolls back an unfinished packet.
    assign base      = trn_rsof ? cmt_ptr : wr_ptr;
    assign beat_bar  = trn_rsof ? trn_rbar_hit : bar_q;
    // cmt_pub lags cmt_ptr by one cycle, giving the two-cycle EOF-to-tvalid latency.
    assign m_axis_rx_tvalid = rd_ptr != cmt_pub;
    assign rd_en            = m_axis_rx_tvalid & m_axis_rx_tready;
    assign rd_word          = mem[rd_ptr[AW-1:0]];
    assign {m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tuser} = m_axis_rx_tvalid ? rd_word : '0;

    // Packet framing: accepted beats follow EOF, overflow drops the rest of the packet.
    always_comb begin
        state_nxt = (ovf | wen) ? (trn_reof ? IDLE : (ovf ? DROP : PKT)) :
                    (state == DROP && trn_rsrc_rdy && trn_reof) ? IDLE : state;
    end

    // Pointers, framing state, error pulses, drop counter and throttle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            cmt_ptr       <= '0;
            cmt_pub       <= '0;
            rd_ptr        <= '0;
            bar_q         <= '0;
            err_overflow  <= 1'b0;
            err_frame     <= 1'b0;
            drop_cnt      <= '0;
            rx_st_ready_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            wr_ptr        <= ovf ? cmt_ptr : wen ? base + PW'(1) : wr_ptr;
            cmt_ptr       <= (wen & trn_reof) ? base + PW'(1) : cmt_ptr;
            cmt_pub       <= cmt_ptr;
            rd_ptr        <= rd_en ? rd_ptr + PW'(1) : rd_ptr;
            bar_q         <= start ? trn_rbar_hit : bar_q;
            err_overflow  <= ovf;
            err_frame     <= frame_bad;
            drop_cnt      <= (ovf && drop_cnt != 16'hFFFF) ? drop_cnt + 16'd1 : drop_cnt;
            rx_st_ready_o <= free > PW'(READY_MARGIN);
        end
    end

    // Beat storage: {data, keep, last, sof, bar}; keep is full on every beat but the last.
    always_ff @(posedge clk) begin
        if (wen) mem[base[AW-1:0]] <= {trn_rd, trn_reof ? trn_rrem : {BE_WIDTH{1'b1}}, trn_reof, trn_rsof, beat_bar};
    end
endmodule

// File: tb/tb_avalon_rx_axis_pkt_fifo.sv
// tb_avalon_rx_axis_pkt_fifo: random and directed packet traffic checked against a queue-based packet model
module tb_avalon_rx_axis_pkt_fifo;
    localparam int DW = 128;
    localparam int BW = 16;
    localparam int DEPTH = 32;
    localparam int MARGIN = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [BW-1:0] k;
        logic          l;
        logic          s;
        logic [7:0]    b;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] trn_rd = '0;
    logic [BW-1:0] trn_rrem = '0;
    logic          sof = 1'b0, eof = 1'b0, src_rdy = 1'b0, tready = 1'b0;
    logic [7:0]    bar = '0;
    logic [DW-1:0] tdata;
    logic [BW-1:0] tkeep;
    logic          tlast, tvalid, ready_o, ovf_o, ferr_o;
    logic [8:0]    tuser;
    logic [15:0]   drop_cnt;

    beat_t vis[$], lag[$], part[$];
    int    st, drops, n_tests, n_fail;
    logic  [7:0] cur_bar;
    bit    exp_ovf, exp_ferr, exp_ready;

    always #5 clk = ~clk;

    avalon_rx_axis_pkt_fifo #(.AXI_DATA_WIDTH(DW), .BE_WIDTH(BW), .FIFO_DEPTH(DEPTH), .READY_MARGIN(MARGIN)) dut (
        .clk(clk), .rst_n(rst_n), .trn_rd(trn_rd), .trn_rrem(trn_rrem), .trn_rsof(sof), .trn_reof(eof),
        .trn_rsrc_rdy(src_rdy), .trn_rbar_hit(bar), .m_axis_rx_tdata(tdata), .m_axis_rx_tkeep(tkeep),
        .m_axis_rx_tlast(tlast), .m_axis_rx_tuser(tuser), .m_axis_rx_tvalid(tvalid), .m_axis_rx_tready(tready),
        .rx_st_ready_o(ready_o), .err_overflow(ovf_o), .err_frame(ferr_o), .drop_cnt(drop_cnt)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        beat_t f;
        check("tvalid", tvalid, vis.size() != 0);
        if (vis.size() != 0) begin
            f = vis[0];
            check("tdata", tdata, f.d);
            check("tkeep", tkeep, f.k);
            check("tlast", tlast, f.l);
            check("tuser", tuser, {f.s, f.b});
        end
        check("err_overflow", ovf_o, exp_ovf);
        check("err_frame", ferr_o, exp_ferr);
        check("drop_cnt", drop_cnt, 16'(drops));
        check("rx_st_ready_o", ready_o, exp_ready);
    endtask

    task automatic drop_partial();
        part.delete();
        exp_ovf = 1'b1;
        if (drops < 65535) drops++;
        st = eof ? 0 : 2;
    endtask

    task automatic accept_beat(input beat_t nb);
        part.push_back(nb);
        if (eof) begin
            foreach (part[i]) lag.push_back(part[i]);
            part.delete();
            st = 0;
        end else st = 1;
    endtask

    // One clock edge of the packet model, using the inputs currently driven.
    task automatic model_step();
        int    stored;
        bit    full;
        beat_t nb;
        stored    = vis.size() + lag.size() + part.size();
        full      = stored == DEPTH;
        exp_ready = (DEPTH - stored) > MARGIN;
        exp_ovf   = 1'b0;
        exp_ferr  = 1'b0;
        if (vis.size() != 0 && tready) void'(vis.pop_front());
        while (lag.size() != 0) vis.push_back(lag.pop_front());
        if (!src_rdy) return;
        nb.d = trn_rd;
        nb.k = eof ? trn_rrem : '1;
        nb.l = eof;
        nb.s = sof;
        if (sof) begin
            if (st != 0) exp_ferr = 1'b1;
            part.delete();
            cur_bar = bar;
            nb.b = bar;
            if (full) drop_partial();
            else accept_beat(nb);
        end else if (st == 0) begin
            exp_ferr = 1'b1;
        end else if (st == 1) begin
            nb.b = cur_bar;
            if (full) drop_partial();
            else accept_beat(nb);
        end else if (eof) begin
            st = 0;
        end
    endtask

    task automatic cycle(input bit v, input bit s, input bit e, input logic [7:0] b, input logic [BW-1:0] rr, input bit rdy);
        @(negedge clk);
        check_outputs();
        src_rdy  = v;
        sof      = s;
        eof      = e;
        bar      = b;
        trn_rrem = rr;
        trn_rd   = {$urandom(), $urandom(), $urandom(), $urandom()};
        tready   = rdy;
        model_step();
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 8'h00, '0, rdy);
    endtask

    task automatic send_pkt(input int len, input logic [7:0] b, input logic [BW-1:0] rr, input int rdy_pct);
        for (int i = 0; i < len; i++)
            cycle(1'b1, i == 0, i == len - 1, (i == 0) ? b : 8'($urandom()), rr, $urandom_range(99, 0) < rdy_pct);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tuser", tuser, 9'h0);
        check("rst_tkeep", tkeep, '0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_ready", ready_o, 1'b0);
        check("rst_drop_cnt", drop_cnt, 16'h0);
        check("rst_err", {ovf_o, ferr_o}, 2'b00);
        vis.delete(); lag.delete(); part.delete();
        st = 0; drops = 0; exp_ovf = 1'b0; exp_ferr = 1'b0; exp_ready = 1'b0;
        src_rdy = 1'b0; sof = 1'b0; eof = 1'b0; tready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_step();
    endtask

    initial begin
        int pct, rem, len;
        logic [7:0] pbar;
        n_tests = 0;
        n_fail = 0;
        do_reset();
        // Single 4-beat packet, latency and tuser/tkeep placement
        send_pkt(4, 8'h01, 16'h00FF, 100);
        idle(8, 1'b1);
        // Back-to-back single-beat packets with throttled tready
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b1, 8'($urandom()), 16'($urandom()), $urandom_range(1, 0) == 1);
        idle(60, 1'b1);
        // Overflow with tready low: 30 committed beats then a 5-beat packet that cannot fit
        do_reset();
        for (int i = 0; i < 10; i++) send_pkt(3, 8'($urandom()), 16'($urandom()), 0);
        idle(2, 1'b0);
        send_pkt(5, 8'hA5, 16'h0F0F, 0);
        idle(3, 1'b0);
        check("t3_drop_cnt", drop_cnt, 16'd1);
        idle(50, 1'b1);
        // Framing errors: SOF inside a packet, then a stray non-SOF beat
        cycle(1'b1, 1'b1, 1'b0, 8'h11, '0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, '0, 1'b1);
        send_pkt(3, 8'h22, 16'h0003, 100);
        cycle(1'b1, 1'b0, 1'b1, 8'h33, 16'h0001, 1'b1);
        idle(10, 1'b1);
        // Reset mid-packet with committed beats still pending
        for (int i = 0; i < 3; i++) send_pkt(1, 8'h44, 16'hFFFF, 0);
        idle(3, 1'b0);
        send_pkt(2, 8'h55, 16'h0, 0);
        do_reset();
        idle(2, 1'b0);
        // Throttle threshold: fill to DEPTH-MARGIN, then free one beat
        for (int i = 0; i < DEPTH - MARGIN; i++) send_pkt(1, 8'h66, 16'h00F0, 0);
        idle(2, 1'b0);
        check("t6_ready_low", ready_o, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        check("t6_ready_high", ready_o, 1'b1);
        idle(40, 1'b1);
        // Randomized traffic with varying downstream pressure
        rem = 0;
        len = 0;
        pbar = '0;
        for (int seg = 0; seg < 15; seg++) begin
            case ($urandom_range(3, 0))
                0: pct = 0;
                1: pct = 30;
                2: pct = 70;
                default: pct = 100;
            endcase
            for (int c = 0; c < 200; c++) begin
                int r = $urandom_range(99, 0);
                bit rdy = $urandom_range(99, 0) < pct;
                if (rem == 0) begin
                    if (r < 25) idle(1, rdy);
                    else if (r < 28) cycle(1'b1, 1'b0, $urandom_range(1, 0) == 1, 8'($urandom()), 16'($urandom()), rdy);
                    else begin
                        len = $urandom_range(6, 1);
                        rem = len;
                        pbar = 8'($urandom());
                    end
                end
                if (rem != 0 && r >= 28) begin
                    if (rem != len && r < 31) rem = 0;
                    else if (r < 38) idle(1, rdy);
                    else begin
                        cycle(1'b1, rem == len, rem == 1, (rem == len) ? pbar : 8'($urandom()), 16'($urandom()), rdy);
                        rem--;
                    end
                end
            end
        end
        idle(80, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
